// File: rtl/acia_rx_fifo.sv
// -----------------------------------------------------------------------------
// acia_rx_fifo
//
// Receive-side character buffer between the ACIA receiver shift stage and the
// CPU register interface. Each received character is stored together with its
// {FRAME, PARITY} error flags. A CPU read of the data register pops one entry.
// The head entry is presented show-ahead on DOUT/DOUT_ERR.
//
// Optional feature macro: ACIA_RX_FIFO_AUTORTS_EN
//   defined   -> RTSB is driven by a two-state hysteresis machine
//                (deasserts at HIGH_WATER, reasserts at LOW_WATER).
//   undefined -> RTSB is tied to 0; HIGH_WATER/LOW_WATER are unused.
//
// Handshake: RX_VALID and RD_STB are single-cycle strobes with no back-pressure
// path. A push is accepted whenever the FIFO is not full, or is full but a pop
// is taken in the same cycle. A pop is taken whenever the FIFO is not empty.
// A push that cannot be accepted is dropped and sets the sticky OVERRUN flag.
//
// Ports:
//   PHI2      in   clock, all state updates on the rising edge
//   RESET     in   synchronous active-high reset
//   RX_DATA   in   [7:0] received character
//   RX_ERR    in   [1:0] {FRAME, PARITY} for RX_DATA
//   RX_VALID  in   push strobe
//   RD_STB    in   pop strobe (CPU read of the data register)
//   OVR_CLR   in   clear of OVERRUN (CPU read of the status register)
//   DOUT      out  [7:0] head character (valid when ~EMPTY)
//   DOUT_ERR  out  [1:0] head {FRAME, PARITY}
//   EMPTY     out  fill level is zero
//   FULL      out  fill level is DEPTH
//   COUNT     out  [AW:0] fill level
//   OVERRUN   out  sticky: a push was dropped
//   LVL_IRQ   out  COUNT >= IRQ_LEVEL
//   RTSB      out  active-low request-to-send; its level is the RTS FSM state
// -----------------------------------------------------------------------------
module acia_rx_fifo #(
   parameter int DEPTH      = 16,
   parameter int AW         = $clog2(DEPTH),
   parameter int HIGH_WATER = 12,
   parameter int LOW_WATER  = 4,
   parameter int IRQ_LEVEL  = 1
) (
   input  logic          PHI2,
   input  logic          RESET,
   input  logic [7:0]    RX_DATA,
   input  logic [1:0]    RX_ERR,
   input  logic          RX_VALID,
   input  logic          RD_STB,
   input  logic          OVR_CLR,
   output logic [7:0]    DOUT,
   output logic [1:0]    DOUT_ERR,
   output logic          EMPTY,
   output logic          FULL,
   output logic [AW:0]   COUNT,
   output logic          OVERRUN,
   output logic          LVL_IRQ,
   output logic          RTSB
);

   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0]   IRQ_L   = (AW+1)'(IRQ_LEVEL);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   // Storage: {err[1:0], data[7:0]} per entry. Not reset; only pointers and
   // count define which entries are live.
   logic [9:0]    mem_q [DEPTH];

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovr_q, ovr_d;

   logic          empty_w;
   logic          full_w;
   logic          push_ok;
   logic          pop_ok;
   logic          drop;

   // Flags decode from the count register only, so no strobe reaches them
   // combinationally.
   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == DEPTH_L);

   // A pop while full frees a slot in the same edge, so the push still fits.
   // A pop while empty is ignored even if a push arrives alongside it.
   assign pop_ok  = RD_STB & ~empty_w;
   assign push_ok = RX_VALID & (~full_w | pop_ok);
   assign drop    = RX_VALID & ~push_ok;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovr_d   = ovr_q;

      if (push_ok) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (pop_ok) begin
         rptr_d = rptr_q + PTR_ONE;
      end

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Set has priority over clear when both occur on the same edge.
      if (OVR_CLR) begin
         ovr_d = 1'b0;
      end
      if (drop) begin
         ovr_d = 1'b1;
      end
   end

   always_ff @(posedge PHI2) begin
      if (RESET) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge PHI2) begin
      if (!RESET && push_ok) begin
         mem_q[wptr_q] <= {RX_ERR, RX_DATA};
      end
   end

   // Show-ahead head entry.
   assign DOUT     = mem_q[rptr_q][7:0];
   assign DOUT_ERR = mem_q[rptr_q][9:8];

   assign EMPTY    = empty_w;
   assign FULL     = full_w;
   assign COUNT    = count_q;
   assign OVERRUN  = ovr_q;
   assign LVL_IRQ  = (count_q >= IRQ_L);

`ifdef ACIA_RX_FIFO_AUTORTS_EN
   localparam logic [AW:0] HIGH_L = (AW+1)'(HIGH_WATER);
   localparam logic [AW:0] LOW_L  = (AW+1)'(LOW_WATER);

   typedef enum logic {
      RTS_ASSERT = 1'b0,   // RTSB = 0, remote may send
      RTS_HOLD   = 1'b1    // RTSB = 1, remote held off
   } rts_state_e;

   rts_state_e rts_state_q, rts_state_d;

   always_ff @(posedge PHI2) begin
      if (RESET) begin
         rts_state_q <= RTS_ASSERT;
      end else begin
         rts_state_q <= rts_state_d;
      end
   end

   // Thresholds compare against the next-cycle count so RTSB changes on the
   // same edge that moves the fill level across a water mark.
   always_comb begin
      rts_state_d = rts_state_q;
      case (rts_state_q)
         RTS_ASSERT: if (count_d >= HIGH_L) rts_state_d = RTS_HOLD;
         RTS_HOLD:   if (count_d <= LOW_L)  rts_state_d = RTS_ASSERT;
         default:    rts_state_d = RTS_ASSERT;
      endcase
   end

   assign RTSB = (rts_state_q == RTS_HOLD);
`else
   assign RTSB = 1'b0;
`endif

endmodule

// File: tb/tb_acia_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_acia_rx_fifo
//
// Directed bench for acia_rx_fifo (DEPTH=16, HIGH_WATER=12, LOW_WATER=4,
// IRQ_LEVEL=1). Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acia_rx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   // ---------------- clock / reset ----------------
   logic          PHI2 = 1'b0;
   logic          RESET;
   logic [7:0]    RX_DATA;
   logic [1:0]    RX_ERR;
   logic          RX_VALID;
   logic          RD_STB;
   logic          OVR_CLR;
   logic [7:0]    DOUT;
   logic [1:0]    DOUT_ERR;
   logic          EMPTY;
   logic          FULL;
   logic [AW:0]   COUNT;
   logic          OVERRUN;
   logic          LVL_IRQ;
   logic          RTSB;

   always #5 PHI2 = ~PHI2;

   acia_rx_fifo #(
      .DEPTH(16), .HIGH_WATER(12), .LOW_WATER(4), .IRQ_LEVEL(1)
   ) dut (
      .PHI2(PHI2), .RESET(RESET),
      .RX_DATA(RX_DATA), .RX_ERR(RX_ERR), .RX_VALID(RX_VALID),
      .RD_STB(RD_STB), .OVR_CLR(OVR_CLR),
      .DOUT(DOUT), .DOUT_ERR(DOUT_ERR),
      .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
      .OVERRUN(OVERRUN), .LVL_IRQ(LVL_IRQ), .RTSB(RTSB)
   );

   // ---------------- scoreboard ----------------
   int         errors = 0;
   int         checks = 0;
   logic [9:0] exp_q[$];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // RTSB expectation: in the default build the pin is tied low.
   function automatic logic exp_rts(input logic hold);
`ifdef ACIA_RX_FIFO_AUTORTS_EN
      return hold;
`else
      return 1'b0 & hold;
`endif
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge PHI2);
      #1;
   endtask

   task automatic idle_inputs();
      RX_DATA  = 8'h00;
      RX_ERR   = 2'b00;
      RX_VALID = 1'b0;
      RD_STB   = 1'b0;
      OVR_CLR  = 1'b0;
   endtask

   task automatic push(input logic [7:0] d, input logic [1:0] e);
      RX_DATA  = d;
      RX_ERR   = e;
      RX_VALID = 1'b1;
      cycle();
      RX_VALID = 1'b0;
   endtask

   task automatic pop();
      RD_STB = 1'b1;
      cycle();
      RD_STB = 1'b0;
   endtask

   // Check the head against the expected queue, then pop it.
   task automatic pop_expect(input string tag);
      logic [9:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_underflow"}, 16'd1, 16'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_dout"}, {8'h00, DOUT}, {8'h00, e[7:0]});
         check({tag, "_err"},  {14'h0, DOUT_ERR}, {14'h0, e[9:8]});
      end
      pop();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      cycle();
      RESET = 1'b0;
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      RESET = 1'b1;
      cycle();
      cycle();
      RESET = 1'b0;

      // Reset state
      check("rst_count",   {11'h0, COUNT}, 16'd0);
      check("rst_empty",   {15'h0, EMPTY}, 16'd1);
      check("rst_full",    {15'h0, FULL}, 16'd0);
      check("rst_ovr",     {15'h0, OVERRUN}, 16'd0);
      check("rst_irq",     {15'h0, LVL_IRQ}, 16'd0);
      check("rst_rtsb",    {15'h0, RTSB}, 16'd0);

      // Three characters with distinct error flags
      push(8'h41, 2'b00);
      check("t1_vis_dout",  {8'h0, DOUT}, 16'h41);
      check("t1_vis_empty", {15'h0, EMPTY}, 16'd0);
      check("t1_irq",       {15'h0, LVL_IRQ}, 16'd1);
      push(8'h42, 2'b10);
      push(8'h43, 2'b01);
      exp_q.push_back({2'b00, 8'h41});
      exp_q.push_back({2'b10, 8'h42});
      exp_q.push_back({2'b01, 8'h43});
      check("t1_count3", {11'h0, COUNT}, 16'd3);
      pop_expect("t1_p0");
      check("t1_count2", {11'h0, COUNT}, 16'd2);
      pop_expect("t1_p1");
      check("t1_count1", {11'h0, COUNT}, 16'd1);
      pop_expect("t1_p2");
      check("t1_count0", {11'h0, COUNT}, 16'd0);
      check("t1_empty",  {15'h0, EMPTY}, 16'd1);
      check("t1_irq0",   {15'h0, LVL_IRQ}, 16'd0);

      // Fill to DEPTH, then overrun
      for (int i = 0; i < DEPTH; i++) begin
         logic [7:0] d;
         logic [1:0] e;
         d = 8'(i * 17 + 3);
         e = 2'(i);
         push(d, e);
         exp_q.push_back({e, d});
      end
      check("t2_full",    {15'h0, FULL}, 16'd1);
      check("t2_count16", {11'h0, COUNT}, 16'd16);
      check("t2_ovr_pre", {15'h0, OVERRUN}, 16'd0);
      push(8'hFF, 2'b11);
      check("t2_ovr",     {15'h0, OVERRUN}, 16'd1);
      check("t2_full2",   {15'h0, FULL}, 16'd1);
      check("t2_count",   {11'h0, COUNT}, 16'd16);
      for (int i = 0; i < DEPTH; i++) begin
         pop_expect($sformatf("t2_d%0d", i));
      end
      check("t2_drained", {15'h0, EMPTY}, 16'd1);
      check("t2_ovr_sticky", {15'h0, OVERRUN}, 16'd1);
      OVR_CLR = 1'b1;
      cycle();
      OVR_CLR = 1'b0;
      check("t2_ovr_clr", {15'h0, OVERRUN}, 16'd0);

      // While full: simultaneous push and pop is accepted, no overrun
      for (int i = 0; i < DEPTH; i++) begin
         push(8'(8'h80 + i), 2'b00);
         exp_q.push_back({2'b00, 8'(8'h80 + i)});
      end
      void'(exp_q.pop_front());          // 0x80 leaves via the paired pop
      exp_q.push_back({2'b01, 8'h55});
      RX_DATA = 8'h55; RX_ERR = 2'b01; RX_VALID = 1'b1; RD_STB = 1'b1;
      cycle();
      RX_VALID = 1'b0; RD_STB = 1'b0;
      check("t3_count",   {11'h0, COUNT}, 16'd16);
      check("t3_ovr",     {15'h0, OVERRUN}, 16'd0);
      check("t3_head",    {8'h0, DOUT}, 16'h81);
      // Drop coinciding with OVR_CLR: set wins
      RX_DATA = 8'hEE; RX_VALID = 1'b1; OVR_CLR = 1'b1;
      cycle();
      RX_VALID = 1'b0; OVR_CLR = 1'b0;
      check("t3_setwins", {15'h0, OVERRUN}, 16'd1);
      for (int i = 0; i < DEPTH; i++) begin
         pop_expect($sformatf("t3_d%0d", i));
      end
      check("t3_empty",   {15'h0, EMPTY}, 16'd1);
      OVR_CLR = 1'b1;
      cycle();
      OVR_CLR = 1'b0;

      // Empty: lone pop ignored; push+pop accepts the push only
      pop();
      check("t4_count0",  {11'h0, COUNT}, 16'd0);
      check("t4_empty",   {15'h0, EMPTY}, 16'd1);
      RX_DATA = 8'h7E; RX_ERR = 2'b00; RX_VALID = 1'b1; RD_STB = 1'b1;
      cycle();
      RX_VALID = 1'b0; RD_STB = 1'b0;
      check("t4_count1",  {11'h0, COUNT}, 16'd1);
      check("t4_dout",    {8'h0, DOUT}, 16'h7E);
      pop();
      check("t4_empty2",  {15'h0, EMPTY}, 16'd1);

      // RTS hysteresis
      for (int i = 1; i <= 12; i++) begin
         push(8'(i), 2'b00);
         check($sformatf("t5_up%0d", i), {15'h0, RTSB}, {15'h0, exp_rts(i >= 12)});
      end
      for (int i = 11; i >= 4; i--) begin
         pop();
         check($sformatf("t5_dn%0d", i), {15'h0, RTSB}, {15'h0, exp_rts(i > 4)});
      end
      check("t5_count4", {11'h0, COUNT}, 16'd4);

      // Reset mid-operation with COUNT=7 and OVERRUN=1
      for (int i = 0; i < 13; i++) push(8'hA0, 2'b00);
      push(8'hA1, 2'b00);                // dropped, sets OVERRUN
      for (int i = 0; i < 9; i++) pop();
      check("t6_pre_count", {11'h0, COUNT}, 16'd7);
      check("t6_pre_ovr",   {15'h0, OVERRUN}, 16'd1);
      do_reset();
      check("t6_count",  {11'h0, COUNT}, 16'd0);
      check("t6_empty",  {15'h0, EMPTY}, 16'd1);
      check("t6_ovr",    {15'h0, OVERRUN}, 16'd0);
      check("t6_irq",    {15'h0, LVL_IRQ}, 16'd0);
      check("t6_rtsb",   {15'h0, RTSB}, 16'd0);
      push(8'h3C, 2'b10);
      check("t6_after_dout", {8'h0, DOUT}, 16'h3C);
      check("t6_after_err",  {14'h0, DOUT_ERR}, 16'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/acia_rx_fifo.md
# acia_rx_fifo

Receive-side byte buffer between the ACIA receiver shift stage and the ACIA CPU register interface. Each completed character is pushed together with its per-character error flags. The CPU-facing read of the data register pops one entry. The block reports fill level, a sticky FIFO overrun, a threshold interrupt request, and optionally drives RTSB with hysteresis so the remote transmitter is held off before the buffer fills.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, 2..256
- AW, $clog2(DEPTH), pointer width
- HIGH_WATER, 12, fill level at or above which RTSB deasserts (auto-RTS only)
- LOW_WATER, 4, fill level at or below which RTSB reasserts; LOW_WATER < HIGH_WATER <= DEPTH
- IRQ_LEVEL, 1, fill level at or above which LVL_IRQ asserts; 1..DEPTH

Ports:
- PHI2  in  1  sole clock; all state updates on its rising edge
- RESET  in  1  synchronous, active-high reset
- RX_DATA  in  8  received character from the receiver
- RX_ERR  in  2  {FRAME, PARITY} for RX_DATA
- RX_VALID  in  1  one-cycle push strobe
- RD_STB  in  1  one-cycle pop strobe (CPU read of data register)
- OVR_CLR  in  1  one-cycle clear of OVERRUN (CPU read of status register)
- DOUT  out  8  head character; show-ahead
- DOUT_ERR  out  2  head {FRAME, PARITY}
- EMPTY  out  1  count == 0
- FULL  out  1  count == DEPTH
- COUNT  out  AW+1  current fill level
- OVERRUN  out  1  sticky: a push was dropped
- LVL_IRQ  out  1  COUNT >= IRQ_LEVEL
- RTSB  out  1  active-low request-to-send toward the remote end

## Operation
- Storage: DEPTH x 10-bit array (data + errors); write pointer, read pointer, and COUNT register. Pointers wrap modulo DEPTH.
- Push: RX_VALID & ~FULL writes {RX_ERR, RX_DATA} at wptr, then wptr+1.
- Pop: RD_STB & ~EMPTY advances rptr.
- RD_STB while EMPTY is ignored. No pointer or count change; DOUT is don't-care.
- Push and pop in the same cycle, not empty: both happen, COUNT unchanged.
- Push and pop in the same cycle while FULL: the pop frees an entry, so the push is accepted and no overrun is flagged.
- Push and pop in the same cycle while EMPTY: the push is accepted, the pop is ignored, COUNT becomes 1.
- Overrun: RX_VALID while FULL without RD_STB drops the character and sets OVERRUN. Stored contents are untouched.
- OVERRUN clears on OVR_CLR. If a drop and OVR_CLR occur in the same cycle, the set wins.
- Error flags travel with their character and are never merged across entries.
- DOUT/DOUT_ERR read the array at rptr combinationally (show-ahead); they are valid whenever ~EMPTY.
- RTSB state machine (auto-RTS), states ASSERT (RTSB=0) and HOLD (RTSB=1):
  - ASSERT -> HOLD when the next-cycle COUNT >= HIGH_WATER.
  - HOLD -> ASSERT when the next-cycle COUNT <= LOW_WATER.
  - Otherwise the state holds.

## Timing
- Reset values: wptr=rptr=0, COUNT=0, EMPTY=1, FULL=0, OVERRUN=0, LVL_IRQ=0, RTSB=0 (ASSERT).
- Reset mid-operation discards all entries; array contents are not cleared.
- Push-to-visibility: a character pushed at edge N appears on DOUT, with EMPTY=0, after edge N.
- Pop latency: DOUT shows the next entry immediately after the RD_STB edge.
- COUNT, EMPTY, FULL, OVERRUN, LVL_IRQ, and RTSB are all registered. Each reflects the operations of the edge just taken, so there is no combinational path from the strobes to these outputs.
- Pushes are accepted back-to-back every cycle; pops likewise.

## Configuration
- ACIA_RX_FIFO_AUTORTS_EN defined: the RTSB hysteresis state machine is built as described.
- Macro undefined: no state machine; RTSB is held at 0 permanently (including during reset). HIGH_WATER and LOW_WATER are unused; all other behaviour is identical.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with RX_ERR=00,10,01; pop three times -> DOUT/DOUT_ERR are 0x41/00, 0x42/10, 0x43/01; COUNT goes 3,2,1,0; EMPTY=1 at the end.
- Fill to DEPTH=16, then push 0xFF -> FULL=1, OVERRUN=1, COUNT=16; draining returns the original 16 bytes with 0xFF absent; OVR_CLR -> OVERRUN=0.
- While FULL, RX_VALID and RD_STB together with 0x55 -> COUNT stays 16, OVERRUN=0; 0x55 is the last byte drained.
- While EMPTY, RD_STB alone -> no change, COUNT=0. RX_VALID and RD_STB together with 0x7E -> COUNT=1, DOUT=0x7E.
- With auto-RTS: push to 12 -> RTSB=1 after that edge; pop down to 5 -> RTSB stays 1; pop to 4 -> RTSB=0.
- Assert RESET with COUNT=7 and OVERRUN=1 -> next cycle COUNT=0, EMPTY=1, OVERRUN=0, LVL_IRQ=0, RTSB=0.
